// File: rtl/ucode_sequencer.sv
// Micro-code sequencer: decodes RV32 instruction words to micro-routine IDs and steps a micro-PC,
// issuing one registered micro-op per step. Define UCODE_SEQ_RV32M_EN to decode the M extension.
module ucode_sequencer #(
    parameter int STEP_W       = 2,
    parameter int LOAD_STEPS   = 3,
    parameter int STORE_STEPS  = 2,
    parameter int BRANCH_STEPS = 2,
    parameter int JUMP_STEPS   = 2,
    parameter int MULDIV_STEPS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [5:0]        uop_id,
    output logic [STEP_W-1:0] uop_step,
    output logic              uop_last,
    output logic              uop_illegal
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    localparam logic [5:0]        ID_ILLEGAL  = 6'd63;
    localparam logic [STEP_W-1:0] ZERO_STEP   = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] LOAD_LAST   = STEP_W'(LOAD_STEPS - 1);
    localparam logic [STEP_W-1:0] STORE_LAST  = STEP_W'(STORE_STEPS - 1);
    localparam logic [STEP_W-1:0] BRANCH_LAST = STEP_W'(BRANCH_STEPS - 1);
    localparam logic [STEP_W-1:0] JUMP_LAST   = STEP_W'(JUMP_STEPS - 1);
    localparam logic [STEP_W-1:0] MULDIV_LAST = STEP_W'(MULDIV_STEPS - 1);

    function automatic logic [5:0] decode_id(input logic [31:0] instr);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] id;
        op = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
        id = ID_ILLEGAL;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  id = 6'd1;
                        3'b001:  id = 6'd6;
                        3'b010:  id = 6'd9;
                        3'b011:  id = 6'd10;
                        3'b100:  id = 6'd5;
                        3'b101:  id = 6'd7;
                        3'b110:  id = 6'd4;
                        3'b111:  id = 6'd3;
                        default: id = ID_ILLEGAL;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  id = 6'd2;
                        3'b101:  id = 6'd8;
                        default: id = ID_ILLEGAL;
                    endcase
                end
`ifdef UCODE_SEQ_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    id = 6'd27 + {3'b000, f3};
                end
`endif
                else begin
                    id = ID_ILLEGAL;
                end
            end
            7'b0010011: begin
                case (f3)
                    3'b000:  id = 6'd14;
                    3'b010:  id = 6'd15;
                    3'b011:  id = 6'd16;
                    3'b100:  id = 6'd17;
                    3'b110:  id = 6'd18;
                    3'b111:  id = 6'd19;
                    3'b001:  id = (f7 == 7'b0000000) ? 6'd20 : ID_ILLEGAL;
                    3'b101:  id = (f7 == 7'b0000000) ? 6'd21 :
                                  (f7 == 7'b0100000) ? 6'd22 : ID_ILLEGAL;
                    default: id = ID_ILLEGAL;
                endcase
            end
            7'b0000011: id = 6'd11;
            7'b0100011: id = 6'd12;
            7'b1100011: id = 6'd13;
            7'b0110111: id = 6'd23;
            7'b0010111: id = 6'd24;
            7'b1101111: id = 6'd25;
            7'b1100111: id = 6'd26;
            default:    id = ID_ILLEGAL;
        endcase
        return id;
    endfunction

    // Index of the final step; multi-step M-extension IDs are unreachable unless enabled in decode.
    function automatic logic [STEP_W-1:0] last_index(input logic [5:0] id);
        logic [STEP_W-1:0] idx;
        case (id)
            6'd11:   idx = LOAD_LAST;
            6'd12:   idx = STORE_LAST;
            6'd13:   idx = BRANCH_LAST;
            6'd25, 6'd26: idx = JUMP_LAST;
            6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34: idx = MULDIV_LAST;
            default: idx = ZERO_STEP;
        endcase
        return idx;
    endfunction

    state_t            state_r, state_nx;
    logic [5:0]        id_r, id_nx;
    logic [STEP_W-1:0] step_r, step_nx;
    logic [STEP_W-1:0] last_idx_r, last_idx_nx;
    logic              last_r, last_nx;
    logic              illegal_r, illegal_nx;
    logic              ready_s;
    logic              accept_s;
    logic [5:0]        dec_id_s;
    logic [STEP_W-1:0] dec_last_s;
    logic [STEP_W-1:0] step_inc_s;
    logic              unused_instr_s;

    assign unused_instr_s = ^{in_instr[24:15], in_instr[11:7]};
    assign dec_id_s       = decode_id(in_instr);
    assign dec_last_s     = last_index(dec_id_s);
    assign step_inc_s     = step_r + STEP_W'(1);
    assign ready_s        = !flush && ((state_r == ST_IDLE) || (uop_ready && last_r));
    assign accept_s       = in_valid && ready_s;

    // State and routine registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            id_r       <= 6'd0;
            step_r     <= ZERO_STEP;
            last_idx_r <= ZERO_STEP;
            last_r     <= 1'b0;
            illegal_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            id_r       <= id_nx;
            step_r     <= step_nx;
            last_idx_r <= last_idx_nx;
            last_r     <= last_nx;
            illegal_r  <= illegal_nx;
        end
    end

    // Next state: flush beats accept, accept beats step advance; idle always carries ID 0.
    always_comb begin
        state_nx    = state_r;
        id_nx       = id_r;
        step_nx     = step_r;
        last_idx_nx = last_idx_r;
        last_nx     = last_r;
        illegal_nx  = illegal_r;
        if (flush) begin
            state_nx    = ST_IDLE;
            id_nx       = 6'd0;
            step_nx     = ZERO_STEP;
            last_idx_nx = ZERO_STEP;
            last_nx     = 1'b0;
            illegal_nx  = 1'b0;
        end else if (accept_s) begin
            state_nx    = ST_ISSUE;
            id_nx       = dec_id_s;
            step_nx     = ZERO_STEP;
            last_idx_nx = dec_last_s;
            last_nx     = (dec_last_s == ZERO_STEP);
            illegal_nx  = (dec_id_s == ID_ILLEGAL);
        end else if ((state_r == ST_ISSUE) && uop_ready) begin
            if (last_r) begin
                state_nx    = ST_IDLE;
                id_nx       = 6'd0;
                step_nx     = ZERO_STEP;
                last_idx_nx = ZERO_STEP;
                last_nx     = 1'b0;
                illegal_nx  = 1'b0;
            end else begin
                step_nx = step_inc_s;
                last_nx = (step_inc_s == last_idx_r);
            end
        end else begin
            state_nx = state_r;
        end
    end

    // Outputs come straight from registers; only in_ready looks at live inputs.
    always_comb begin
        in_ready    = ready_s;
        uop_valid   = (state_r == ST_ISSUE);
        uop_id      = id_r;
        uop_step    = step_r;
        uop_last    = last_r;
        uop_illegal = illegal_r;
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: decode table, hand-written corner sequences and
// randomized traffic compared against a cycle-level reference model of the handshake rules.
module tb_ucode_sequencer;
    localparam int STEP_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              uop_ready = 1'b0;
    logic [31:0]       in_instr = 32'h0;
    logic              in_ready, uop_valid, uop_last, uop_illegal;
    logic [5:0]        uop_id;
    logic [STEP_W-1:0] uop_step;

    ucode_sequencer dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_id(uop_id),
        .uop_step(uop_step), .uop_last(uop_last), .uop_illegal(uop_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          id;
        int          steps;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // reference model: is a routine active, which one, how long, and where in it
    bit m_valid = 1'b0;
    int m_id = 0;
    int m_steps = 1;
    int m_step = 0;

    function automatic logic [31:0] mk(logic [6:0] f7, logic [2:0] f3, logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic int ref_id(logic [31:0] w);
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        int rtab[8] = '{1, 6, 9, 10, 5, 7, 4, 3};
        int itab[8] = '{14, 20, 15, 16, 17, 21, 18, 19};
        if (op == 'h33) begin
            if (f7 == 0) return rtab[f3];
            if (f7 == 32 && f3 == 0) return 2;
            if (f7 == 32 && f3 == 5) return 8;
`ifdef UCODE_SEQ_RV32M_EN
            if (f7 == 1) return 27 + f3;
`endif
            return 63;
        end
        if (op == 'h13) begin
            if (f3 == 1) return (f7 == 0) ? 20 : 63;
            if (f3 == 5) return (f7 == 0) ? 21 : ((f7 == 32) ? 22 : 63);
            return itab[f3];
        end
        case (op)
            'h03: return 11;
            'h23: return 12;
            'h63: return 13;
            'h37: return 23;
            'h17: return 24;
            'h6F: return 25;
            'h67: return 26;
            default: return 63;
        endcase
    endfunction

    function automatic int ref_steps(int id);
        if (id == 11) return 3;
        if (id == 12 || id == 13 || id == 25 || id == 26) return 2;
        if (id >= 27 && id <= 34) return 4;
        return 1;
    endfunction

    function automatic bit model_last();
        return m_valid && (m_step == m_steps - 1);
    endfunction

    function automatic bit model_ready();
        return !flush && (!m_valid || (uop_ready && model_last()));
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_vec(logic [31:0] instr, int id, int steps);
        vec_t v;
        v.instr = instr;
        v.id = id;
        v.steps = steps;
        vecs.push_back(v);
    endtask

    task automatic drive(bit v, logic [31:0] instr, bit rdy, bit fl);
        in_valid = v;
        in_instr = instr;
        uop_ready = rdy;
        flush = fl;
    endtask

    // compare DUT with the model half a cycle away from the active edge
    task automatic sample();
        @(negedge clk);
        chk("in_ready", int'(in_ready), int'(model_ready()));
        chk("uop_valid", int'(uop_valid), int'(m_valid));
        chk("uop_id", int'(uop_id), m_valid ? m_id : 0);
        chk("uop_step", int'(uop_step), m_valid ? m_step : 0);
        chk("uop_last", int'(uop_last), int'(model_last()));
        chk("uop_illegal", int'(uop_illegal), int'(m_valid && m_id == 63));
    endtask

    task automatic advance();
        bit rdy;
        @(posedge clk);
        rdy = model_ready();
        if (!reset) begin
            m_valid = 1'b0;
            m_step = 0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_id = ref_id(in_instr);
            m_steps = ref_steps(m_id);
            m_step = 0;
        end else if (m_valid && uop_ready) begin
            if (m_step == m_steps - 1) m_valid = 1'b0;
            else m_step++;
        end
        #1;
    endtask

    localparam logic [31:0] W_ADD  = 32'h002081B3;
    localparam logic [31:0] W_LW   = 32'h0000A183;
    localparam logic [31:0] W_SW   = 32'h0020A023;
    localparam logic [31:0] W_JAL  = 32'h0000006F;
    localparam logic [31:0] W_ADDI = 32'h00108093;

    initial begin
        add_vec(W_ADD, 1, 1);
        add_vec(mk(7'h20, 3'd0, 7'h33), 2, 1);
        add_vec(mk(7'h00, 3'd7, 7'h33), 3, 1);
        add_vec(mk(7'h00, 3'd6, 7'h33), 4, 1);
        add_vec(mk(7'h00, 3'd4, 7'h33), 5, 1);
        add_vec(mk(7'h00, 3'd1, 7'h33), 6, 1);
        add_vec(mk(7'h00, 3'd5, 7'h33), 7, 1);
        add_vec(mk(7'h20, 3'd5, 7'h33), 8, 1);
        add_vec(mk(7'h00, 3'd2, 7'h33), 9, 1);
        add_vec(mk(7'h00, 3'd3, 7'h33), 10, 1);
        add_vec(W_LW, 11, 3);
        add_vec(W_SW, 12, 2);
        add_vec(mk(7'h00, 3'd1, 7'h63), 13, 2);
        add_vec(W_ADDI, 14, 1);
        add_vec(mk(7'h00, 3'd2, 7'h13), 15, 1);
        add_vec(mk(7'h00, 3'd3, 7'h13), 16, 1);
        add_vec(mk(7'h00, 3'd4, 7'h13), 17, 1);
        add_vec(mk(7'h00, 3'd6, 7'h13), 18, 1);
        add_vec(mk(7'h7F, 3'd7, 7'h13), 19, 1);
        add_vec(mk(7'h00, 3'd1, 7'h13), 20, 1);
        add_vec(mk(7'h00, 3'd5, 7'h13), 21, 1);
        add_vec(mk(7'h20, 3'd5, 7'h13), 22, 1);
        add_vec(mk(7'h12, 3'd3, 7'h37), 23, 1);
        add_vec(mk(7'h12, 3'd3, 7'h17), 24, 1);
        add_vec(W_JAL, 25, 2);
        add_vec(mk(7'h00, 3'd0, 7'h67), 26, 2);
        add_vec(32'h4020F1B3, 63, 1);
        add_vec(32'hFFFFFFFF, 63, 1);
        add_vec(mk(7'h20, 3'd1, 7'h13), 63, 1);
        add_vec(mk(7'h02, 3'd0, 7'h33), 63, 1);
        add_vec(mk(7'h08, 3'd5, 7'h13), 63, 1);
`ifdef UCODE_SEQ_RV32M_EN
        add_vec(32'h022081B3, 27, 4);
        add_vec(mk(7'h01, 3'd7, 7'h33), 34, 4);
`else
        add_vec(32'h022081B3, 63, 1);
        add_vec(mk(7'h01, 3'd7, 7'h33), 63, 1);
`endif

        // asynchronous reset state
        #2 reset = 1'b0;
        #10;
        chk("rst_valid", int'(uop_valid), 0);
        chk("rst_id", int'(uop_id), 0);
        chk("rst_step", int'(uop_step), 0);
        chk("rst_last", int'(uop_last), 0);
        chk("rst_illegal", int'(uop_illegal), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // first ADD, one-cycle latency
        drive(1'b1, W_ADD, 1'b1, 1'b0);
        sample();
        chk("add_ready_idle", int'(in_ready), 1);
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        chk("add_valid", int'(uop_valid), 1);
        chk("add_id", int'(uop_id), 1);
        chk("add_step", int'(uop_step), 0);
        chk("add_last", int'(uop_last), 1);
        chk("add_ready", int'(in_ready), 1);
        advance();

        // LW over three steps with ADDI queued behind it
        drive(1'b1, W_LW, 1'b1, 1'b0);
        sample();
        advance();
        drive(1'b1, W_ADDI, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            sample();
            chk("lw_id", int'(uop_id), 11);
            chk("lw_step", int'(uop_step), s);
            chk("lw_last", int'(uop_last), int'(s == 2));
            chk("lw_in_ready", int'(in_ready), int'(s == 2));
            advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        chk("addi_no_bubble_valid", int'(uop_valid), 1);
        chk("addi_no_bubble_id", int'(uop_id), 14);
        advance();
        sample();
        advance();

        // SW stalled three cycles at step 0
        drive(1'b1, W_SW, 1'b1, 1'b0);
        sample();
        advance();
        drive(1'b1, W_ADD, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            sample();
            chk("sw_stall_id", int'(uop_id), 12);
            chk("sw_stall_step", int'(uop_step), 0);
            chk("sw_stall_last", int'(uop_last), 0);
            chk("sw_stall_ready", int'(in_ready), 0);
            advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        chk("sw_resume_step", int'(uop_step), 0);
        advance();
        sample();
        chk("sw_step1", int'(uop_step), 1);
        chk("sw_last1", int'(uop_last), 1);
        advance();
        sample();
        chk("sw_done", int'(uop_valid), 0);
        advance();

        // flush at JAL step 0 wins over a pending accept
        drive(1'b1, W_JAL, 1'b1, 1'b0);
        sample();
        advance();
        drive(1'b1, W_ADD, 1'b1, 1'b1);
        sample();
        chk("flush_jal_id", int'(uop_id), 25);
        chk("flush_ready", int'(in_ready), 0);
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        chk("flush_valid", int'(uop_valid), 0);
        chk("flush_id", int'(uop_id), 0);
        advance();

        // reset asserted mid-LW at step 1 clears outputs without a clock edge
        drive(1'b1, W_LW, 1'b1, 1'b0);
        sample();
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        sample();
        advance();
        chk("pre_rst_step", int'(uop_step), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", int'(uop_valid), 0);
        chk("midrst_id", int'(uop_id), 0);
        chk("midrst_step", int'(uop_step), 0);
        chk("midrst_last", int'(uop_last), 0);
        advance();
        reset = 1'b1;
        sample();
        chk("post_rst_ready", int'(in_ready), 1);
        advance();

        // decode table: each entry issued from idle and walked to completion
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, 1'b1, 1'b0);
            sample();
            advance();
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            for (int s = 0; s < vecs[i].steps; s++) begin
                sample();
                chk($sformatf("tbl%0d_id", i), int'(uop_id), vecs[i].id);
                chk($sformatf("tbl%0d_step", i), int'(uop_step), s);
                chk($sformatf("tbl%0d_last", i), int'(uop_last), int'(s == vecs[i].steps - 1));
                chk($sformatf("tbl%0d_illegal", i), int'(uop_illegal), int'(vecs[i].id == 63));
                advance();
            end
            sample();
            chk($sformatf("tbl%0d_idle", i), int'(uop_valid), 0);
            advance();
        end

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] w;
            if ($urandom_range(0, 1) == 0) w = vecs[$urandom_range(0, vecs.size() - 1)].instr;
            else w = $urandom;
            drive(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 19) == 0));
            sample();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised successor to the combinational opcode-to-microcode-address decoder.
- Accepts RV32 instruction words over a valid/ready handshake and decodes each to a 6-bit micro-routine ID.
- Steps a micro-PC through a per-class number of micro-steps, emitting one registered micro-op per step to the datapath control.
- Sits between fetch/IR and the control ROM.

Parameters:
- STEP_W, 2, width of micro-step index; every step count must be in 1..2^STEP_W.
- LOAD_STEPS, 3, micro-steps for load (ID 11).
- STORE_STEPS, 2, micro-steps for store (ID 12).
- BRANCH_STEPS, 2, micro-steps for branch (ID 13).
- JUMP_STEPS, 2, micro-steps for JAL/JALR (IDs 25, 26).
- MULDIV_STEPS, 4, micro-steps for M-extension ops (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of current and pending sequence
- in_valid  in  1  instruction word valid
- in_ready  out  1  sequencer can accept an instruction this cycle
- in_instr  in  32  instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  control ROM/datapath accepts micro-op
- uop_id  out  6  micro-routine ID
- uop_step  out  STEP_W  step index within routine, starting at 0
- uop_last  out  1  final step of routine
- uop_illegal  out  1  routine is the illegal-instruction trap (ID 63)

Behaviour:
- Decode table (ID):
  - R-type 0110011: ADD 1, SUB 2, AND 3, OR 4, XOR 5, SLL 6, SRL 7, SRA 8, SLT 9, SLTU 10.
  - LOAD 0000011: 11. STORE 0100011: 12. BRANCH 1100011: 13.
  - OP-IMM 0010011: ADDI 14, SLTI 15, SLTIU 16, XORI 17, ORI 18, ANDI 19, SLLI 20, SRLI 21, SRAI 22.
  - LUI 0110111: 23. AUIPC 0010111: 24. JAL 1101111: 25. JALR 1100111: 26.
  - Anything else, including a bad funct7 on ADD/SUB/SRL/SRA/SLLI/SRLI/SRAI: 63.
- ID 0 is reserved as the idle/NOP routine. uop_id reads 0 whenever uop_valid=0.
- Step count: parameter-selected for IDs 11, 12, 13, 25, 26. All other IDs, including 63, take 1 step.
- FSM has two states:
  - IDLE: uop_valid=0.
  - ISSUE: uop_valid=1; holds routine ID, total steps and current step.
- in_ready = !flush && (state==IDLE || (uop_ready && uop_last)). Back-to-back issue has no bubble.
- Accept on in_valid && in_ready at edge N: at N+1 uop_valid=1, uop_step=0, uop_id=decoded ID. Latency is 1 cycle.
- In ISSUE with uop_ready=1 and !uop_last: uop_step increments at the next edge.
- In ISSUE with uop_ready=1 and uop_last:
  - if a new instruction is accepted the same cycle, load it;
  - otherwise go to IDLE.
- uop_last = (uop_step == steps-1). uop_illegal = (uop_id==63).
- Stall: while uop_valid && !uop_ready, all uop_* outputs hold stable.
- in_instr is sampled only on accept; later changes to it have no effect.
- flush has highest priority: next state IDLE, uop_valid=0, no accept that cycle, regardless of in_valid or uop_ready.
- Reset (asynchronous, any time, including mid-sequence):
  - state IDLE, step counter 0;
  - uop_valid=0, uop_id=0, uop_step=0, uop_last=0, uop_illegal=0;
  - in_ready=1 after release (when flush=0).
- Step counter never wraps past steps-1. A step value equal to 2^STEP_W-1 is legal when steps=2^STEP_W.

Optional Feature:
- Macro: UCODE_SEQ_RV32M_EN.
- Defined: opcode 0110011 with funct7 0000001 decodes by funct3 to MUL 27, MULH 28, MULHSU 29, MULHU 30, DIV 31, DIVU 32, REM 33, REMU 34, each taking MULDIV_STEPS steps.
- Undefined: these encodings decode to 63 (illegal, 1 step), and MULDIV_STEPS is ignored.

Test Plan:
- Reset low, then release; in_instr=0x002081B3 (ADD), in_valid=1, uop_ready=1 -> next cycle uop_valid=1, id=1, step=0, last=1, in_ready=1.
- LW 0x0000A183 with default parameters, uop_ready=1 -> steps 0, 1, 2 on three consecutive cycles with id=11, last only at step 2; a queued ADDI is accepted in the step-2 cycle and issues id=14 the next cycle with no bubble.
- SW 0x0020A023 with uop_ready held 0 for 3 cycles at step 0 -> outputs stable and in_ready=0 throughout; completes 2 steps after uop_ready rises.
- in_instr=0x4020F1B3 (funct7=0100000, funct3=111) -> id=63, uop_illegal=1, last=1. 0xFFFFFFFF -> id=63.
- JAL at step 0 with flush=1 and in_valid=1 -> next cycle uop_valid=0, instruction not accepted. Separately, reset asserted mid-LW step 1 -> outputs clear immediately without waiting for a clock edge.
- With UCODE_SEQ_RV32M_EN: 0x022081B3 (MUL) -> id=27 over 4 steps. Without the macro: same word -> id=63, 1 step.
